// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone initiator: one valid/ready command becomes one
// classic-pipelined bus cycle, finished by a one-cycle response or a timeout.
module wb_initiator #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_dat,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_sta_i,
  input  logic [31:0] wbm_dat_i
);

  // state  | meaning
  // S_IDLE | ready for a command
  // S_REQ  | cyc+stb asserted, waiting for the slave to take the request
  // S_WAIT | request taken, cyc held until ack or timeout
  // S_RESP | one-cycle response pulse
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_tmo_cnt;
  logic        r_we;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic        r_rsp_err;
  logic [31:0] r_rsp_dat;
  logic        w_accept;
  logic        w_complete;
  logic        w_expire;
  logic        w_tmo_tc;
  logic        w_active;

  assign w_tmo_tc = (r_tmo_cnt == 16'd0);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    wbm_cyc_o   = 1'b0;
    wbm_stb_o   = 1'b0;
    rsp_valid   = 1'b0;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    w_expire    = 1'b0;
    w_active    = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        w_active  = 1'b1;
        // An ack in the terminal cycle still counts as a normal completion.
        if (wbm_ack_i) begin
          w_complete  = 1'b1;
          w_state_nxt = S_RESP;
        end else if (w_tmo_tc) begin
          w_expire    = 1'b1;
          w_state_nxt = S_RESP;
        end else if (!wbm_sta_i) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        wbm_cyc_o = 1'b1;
        w_active  = 1'b1;
        if (wbm_ack_i) begin
          w_complete  = 1'b1;
          w_state_nxt = S_RESP;
        end else if (w_tmo_tc) begin
          w_expire    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_tmo_cnt <= 16'd0;
      r_we      <= 1'b0;
      r_adr     <= 32'd0;
      r_dat     <= 32'd0;
      r_rsp_err <= 1'b0;
      r_rsp_dat <= 32'd0;
    end else begin
      if (w_accept) begin
        r_we      <= cmd_we;
        r_adr     <= cmd_adr;
        r_dat     <= cmd_dat;
        r_tmo_cnt <= TMO_LOAD;
      end else if (w_active && !w_tmo_tc) begin
        r_tmo_cnt <= r_tmo_cnt - 16'd1;
      end
      if (w_complete) begin
        r_rsp_err <= 1'b0;
        r_rsp_dat <= r_we ? 32'd0 : wbm_dat_i;
      end else if (w_expire) begin
        r_rsp_err <= 1'b1;
        r_rsp_dat <= 32'd0;
      end
    end
  end

  assign wbm_we_o  = r_we;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign wbm_sel_o = {4{wbm_stb_o}};
  assign rsp_err   = r_rsp_err;
  assign rsp_dat   = r_rsp_dat;

endmodule

// File: doc/wb_initiator.md
# wb_initiator

Single-outstanding Wishbone initiator that turns a simple valid/ready command port into one Wishbone read or write cycle and returns a one-cycle response. It sits between a local controller (test sequencer, button-driven script, debug UART) and the Wishbone bus, driving the same slave peripherals (LED/button register blocks at 0x3000_0000 upward). A bounded timeout ends cycles to unmapped addresses, since those slaves never ack.

## Interface
- TIMEOUT, 16: cycles from `wbm_cyc_o` rising to forced abort without ack; legal range 2..65535.
- wb_clk_i  in  1  single clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE; command accepted when `cmd_valid && cmd_ready`.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  32  byte address.
- cmd_dat  in  32  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse; command finished.
- rsp_err  out  1  valid with `rsp_valid`; 1 = timed out.
- rsp_dat  out  32  read data; 0 for writes and timeouts; held until next `rsp_valid`.
- wbm_cyc_o  out  1  bus cycle active.
- wbm_stb_o  out  1  request strobe.
- wbm_we_o  out  1  write enable.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_sel_o  out  4  byte selects; always 4'b1111 while `wbm_stb_o`, else 0.
- wbm_ack_i  in  1  slave completion.
- wbm_sta_i  in  1  slave stall; request not accepted while high.
- wbm_dat_i  in  32  read data, valid when `wbm_ack_i` is high.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: `cmd_ready`=1. On accept, register `cmd_we`/`cmd_adr`/`cmd_dat` into `wbm_we_o`/`wbm_adr_o`/`wbm_dat_o`, clear timeout counter, go to REQ.
- REQ: `wbm_cyc_o`=`wbm_stb_o`=1. If `wbm_ack_i`, complete. Else if `!wbm_sta_i`, go to WAIT (request accepted this cycle). Else stay.
- WAIT: `wbm_cyc_o`=1, `wbm_stb_o`=0. On `wbm_ack_i`, complete.
- Complete: capture `wbm_dat_i` into `rsp_dat` (reads) or 0 (writes), `rsp_err`=0, go to RESP.
- Timeout: counter increments each cycle in REQ/WAIT. When it reaches TIMEOUT-1 with no ack in that cycle, go to RESP with `rsp_err`=1, `rsp_dat`=0. An ack in the same cycle wins over the timeout.
- RESP: `wbm_cyc_o`=`wbm_stb_o`=0, `rsp_valid`=1 for exactly one cycle, then IDLE.
- `wbm_ack_i` outside REQ/WAIT is ignored.
- `wbm_adr_o`/`wbm_dat_o`/`wbm_we_o` hold from accept until the next accept.
- Reset: all outputs 0 except `cmd_ready`=1 (IDLE), `rsp_dat`=0. Mid-cycle reset drops `wbm_cyc_o`/`wbm_stb_o` on that edge, produces no `rsp_valid`, and discards the command.

## Timing
- Accept at edge N: `wbm_cyc_o`/`wbm_stb_o` high from cycle N+1.
- No stall: `wbm_stb_o` high one cycle (N+1), low from N+2.
- Registered-ack slave: ack in N+2, `rsp_valid` in N+3, `cmd_ready` in N+4. Minimum command-to-command spacing is 4 cycles.
- Each stall cycle extends REQ by one cycle.
- Timeout: `wbm_cyc_o` is high for exactly TIMEOUT cycles, then `rsp_valid` follows in the next cycle.
- `wbm_cyc_o` falls in the same cycle `rsp_valid` rises.

## Test plan
- Write to LED slave at 0x3000_0000: `cmd_we`=1, `cmd_dat`=0x0000_00A5 -> `wbm_stb_o` for 1 cycle, ack, `rsp_valid` 3 cycles after accept with `rsp_err`=0, `rsp_dat`=0, slave `leds`=0xA5.
- Read 0x3000_0004 with buttons=0x3C -> `rsp_dat`=0x0000_003C, `rsp_err`=0.
- Read unmapped 0x3000_0008, TIMEOUT=16 -> `wbm_cyc_o` high exactly 16 cycles, then `rsp_valid`=1, `rsp_err`=1, `rsp_dat`=0.
- Stall model: `wbm_sta_i` high for 3 cycles after `wbm_stb_o` rises -> `wbm_stb_o` high 4 cycles, `wbm_adr_o` stable throughout, a single ack, response correct.
- Assert `wb_rst_i` in WAIT -> next cycle `wbm_cyc_o`=0, `cmd_ready`=1, and no `rsp_valid` even if a late ack arrives.
- Back-to-back: `cmd_valid` held with write 0x11 then read 0x3000_0000 -> second accept exactly 4 cycles after the first, read returns 0x11.
